// File: rtl/axi_write_arbiter.sv
// axi_write_arbiter: round-robin share of one AXI3 write port between two masters,
// one transaction in flight, grant held from AW through B, WLAST regenerated from AWLEN.
module axi_write_arbiter #(
    parameter int buswidth = 32
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                m0_AWID,
    input  logic [31:0]         m0_AWADDR,
    input  logic [3:0]          m0_AWLEN,
    input  logic [2:0]          m0_AWSIZE,
    input  logic [1:0]          m0_AWBURST,
    input  logic                m0_AWVALID,
    output logic                m0_AWREADY,
    input  logic                m0_WID,
    input  logic [buswidth-1:0] m0_WDATA,
    input  logic [3:0]          m0_WSTRB,
    input  logic                m0_WLAST,
    input  logic                m0_WVALID,
    output logic                m0_WREADY,
    output logic                m0_BID,
    output logic [1:0]          m0_BRESP,
    output logic                m0_BVALID,
    input  logic                m0_BREADY,
    input  logic                m1_AWID,
    input  logic [31:0]         m1_AWADDR,
    input  logic [3:0]          m1_AWLEN,
    input  logic [2:0]          m1_AWSIZE,
    input  logic [1:0]          m1_AWBURST,
    input  logic                m1_AWVALID,
    output logic                m1_AWREADY,
    input  logic                m1_WID,
    input  logic [buswidth-1:0] m1_WDATA,
    input  logic [3:0]          m1_WSTRB,
    input  logic                m1_WLAST,
    input  logic                m1_WVALID,
    output logic                m1_WREADY,
    output logic                m1_BID,
    output logic [1:0]          m1_BRESP,
    output logic                m1_BVALID,
    input  logic                m1_BREADY,
    output logic                s_AWID,
    output logic [31:0]         s_AWADDR,
    output logic [3:0]          s_AWLEN,
    output logic [2:0]          s_AWSIZE,
    output logic [1:0]          s_AWBURST,
    output logic                s_AWVALID,
    input  logic                s_AWREADY,
    output logic                s_WID,
    output logic [buswidth-1:0] s_WDATA,
    output logic [3:0]          s_WSTRB,
    output logic                s_WLAST,
    output logic                s_WVALID,
    input  logic                s_WREADY,
    input  logic                s_BID,
    input  logic [1:0]          s_BRESP,
    input  logic                s_BVALID,
    output logic                s_BREADY,
    output logic                grant,
    output logic                busy,
    output logic                err_wlast
);
    localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3;
    logic [1:0] state_q, state_d;
    logic       grant_q, grant_d, last_q, last_d, err_q, err_d;
    logic [3:0] beat_q, beat_d, len_q, len_d;
    logic       in_addr, in_data, in_resp, g, beat_last, m_wlast;
    assign g         = grant_q;
    assign in_addr   = state_q == ADDR;
    assign in_data   = state_q == DATA;
    assign in_resp   = state_q == RESP;
    assign beat_last = beat_q == len_q;
    assign m_wlast   = g ? m1_WLAST : m0_WLAST;
    // Payloads are zeroed outside their phase so the slave never sees stale data.
    assign s_AWID     = in_addr ? (g ? m1_AWID : m0_AWID) : 1'b0;
    assign s_AWADDR   = in_addr ? (g ? m1_AWADDR : m0_AWADDR) : '0;
    assign s_AWLEN    = in_addr ? (g ? m1_AWLEN : m0_AWLEN) : '0;
    assign s_AWSIZE   = in_addr ? (g ? m1_AWSIZE : m0_AWSIZE) : '0;
    assign s_AWBURST  = in_addr ? (g ? m1_AWBURST : m0_AWBURST) : '0;
    assign s_AWVALID  = in_addr && (g ? m1_AWVALID : m0_AWVALID);
    assign m0_AWREADY = in_addr && !g && s_AWREADY;
    assign m1_AWREADY = in_addr && g && s_AWREADY;
    assign s_WID      = in_data ? (g ? m1_WID : m0_WID) : 1'b0;
    assign s_WDATA    = in_data ? (g ? m1_WDATA : m0_WDATA) : '0;
    assign s_WSTRB    = in_data ? (g ? m1_WSTRB : m0_WSTRB) : '0;
    assign s_WLAST    = in_data && beat_last;
    assign s_WVALID   = in_data && (g ? m1_WVALID : m0_WVALID);
    assign m0_WREADY  = in_data && !g && s_WREADY;
    assign m1_WREADY  = in_data && g && s_WREADY;
    assign s_BREADY   = in_resp && (g ? m1_BREADY : m0_BREADY);
    assign m0_BVALID  = in_resp && !g && s_BVALID;
    assign m1_BVALID  = in_resp && g && s_BVALID;
    assign m0_BID     = (in_resp && !g) ? s_BID : 1'b0;
    assign m1_BID     = (in_resp && g) ? s_BID : 1'b0;
    assign m0_BRESP   = (in_resp && !g) ? s_BRESP : 2'b00;
    assign m1_BRESP   = (in_resp && g) ? s_BRESP : 2'b00;
    assign grant      = grant_q;
    assign busy       = state_q != IDLE;
    assign err_wlast  = err_q;
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beat_d  = beat_q;
        len_d   = len_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (m0_AWVALID || m1_AWVALID) begin
                grant_d = (m0_AWVALID && m1_AWVALID) ? ~last_q : m1_AWVALID;
                state_d = ADDR;
            end
            ADDR: if (s_AWVALID && s_AWREADY) begin
                len_d   = g ? m1_AWLEN : m0_AWLEN;
                beat_d  = 4'd0;
                state_d = DATA;
            end
            DATA: if (s_WVALID && s_WREADY) begin
                beat_d  = beat_last ? beat_q : beat_q + 4'd1;
                err_d   = err_q | (m_wlast != beat_last);
                state_d = beat_last ? RESP : DATA;
            end
            default: if (s_BVALID && s_BREADY) begin
                last_d  = grant_q;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            beat_q  <= 4'd0;
            len_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end
endmodule
